ysyx_22050854_exu_seq: RTL and testbench

//  Execute-stage sequencer for the RV64 core. Accepts one decoded op from ID, drives operand

---
 rtl/ysyx_22050854_pkg.sv | 38 +++
 rtl/ysyx_22050854_exu_sel_dec.sv | 65 ++++++
 rtl/ysyx_22050854_exu_seq.sv | 170 +++++++++++++++++
 tb/tb_ysyx_22050854_exu_seq.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050854_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22050854_pkg
// Shared definitions for the execute-stage sequencer of the RV64 core:
//   - op-class encodings presented by ID on in_opc_i
//   - ALUsrc1 / ALUsrc2 operand-select encodings
//   - sequencer FSM state enumeration
// ---------------------------------------------------------------------------
package ysyx_22050854_pkg;

    // Op classes delivered by the decoder
    localparam logic [2:0] OPC_OP    = 3'd0;
    localparam logic [2:0] OPC_OPIMM = 3'd1;
    localparam logic [2:0] OPC_AUIPC = 3'd2;
    localparam logic [2:0] OPC_JUMP  = 3'd3;
    localparam logic [2:0] OPC_LDST  = 3'd4;
    localparam logic [2:0] OPC_MUL   = 3'd5;
    localparam logic [2:0] OPC_DIV   = 3'd6;
    localparam logic [2:0] OPC_ILL   = 3'd7;

    // First ALU operand: register source or program counter
    localparam logic SRC1_RS1 = 1'b0;
    localparam logic SRC1_PC  = 1'b1;

    // Second ALU operand: register, immediate or the link constant 4.
    // Encoding 2'b11 is reserved and never produced.
    localparam logic [1:0] SRC2_RS2  = 2'b00;
    localparam logic [1:0] SRC2_IMM  = 2'b01;
    localparam logic [1:0] SRC2_FOUR = 2'b10;

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } exu_state_e;

endpackage

// File: rtl/ysyx_22050854_exu_sel_dec.sv
// ---------------------------------------------------------------------------
// ysyx_22050854_exu_sel_dec
// Purely combinational op-class decoder for the execute sequencer.
// Ports:
//   opc_i     in  3  op class from ID
//   src1_o    out 1  ALUsrc1 select (0 = rs1, 1 = pc)
//   src2_o    out 2  ALUsrc2 select (00 = rs2, 01 = imm, 10 = const 4)
//   isMdu_o   out 1  op must go to the shared MUL/DIV unit
//   isDiv_o   out 1  MUL/DIV op is a divide
//   isIll_o   out 1  illegal op class
// ---------------------------------------------------------------------------
module ysyx_22050854_exu_sel_dec
    import ysyx_22050854_pkg::*;
(
    input  logic [2:0] opc_i,
    output logic       src1_o,
    output logic [1:0] src2_o,
    output logic       isMdu_o,
    output logic       isDiv_o,
    output logic       isIll_o
);

    // Map each op class onto its operand selects and routing flags.
    // MUL/DIV and illegal ops use the neutral rs1/rs2 selects.
    always_comb begin
        src1_o  = SRC1_RS1;
        src2_o  = SRC2_RS2;
        isMdu_o = 1'b0;
        isDiv_o = 1'b0;
        isIll_o = 1'b0;
        case (opc_i)
            OPC_OP: begin
                src1_o = SRC1_RS1;
                src2_o = SRC2_RS2;
            end
            OPC_OPIMM: begin
                src1_o = SRC1_RS1;
                src2_o = SRC2_IMM;
            end
            OPC_AUIPC: begin
                src1_o = SRC1_PC;
                src2_o = SRC2_IMM;
            end
            OPC_JUMP: begin
                src1_o = SRC1_PC;
                src2_o = SRC2_FOUR;
            end
            OPC_LDST: begin
                src1_o = SRC1_RS1;
                src2_o = SRC2_IMM;
            end
            OPC_MUL: begin
                isMdu_o = 1'b1;
            end
            OPC_DIV: begin
                isMdu_o = 1'b1;
                isDiv_o = 1'b1;
            end
            default: begin
                isIll_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_22050854_exu_seq.sv
// ---------------------------------------------------------------------------
// ysyx_22050854_exu_seq
// Execute-stage sequencer. Accepts one decoded op from ID, registers the ALU
// operand selects, completes ALU ops in one cycle and hands MUL/DIV ops to the
// shared iterative unit, waiting for its done pulse (with a timeout guard).
// Ports:
//   clk_i, rst_i               clock (rising edge), async active-high reset
//   in_valid_i / in_ready_o    ID handshake
//   in_opc_i                   op class (see ysyx_22050854_pkg)
//   flush_i                    kill in-flight op (redirect / trap)
//   ALUsrc1_o, ALUsrc2_o       operand selects, held until next accept
//   mdu_valid_o / mdu_ready_i  request handshake to the MUL/DIV unit
//   mdu_is_div_o               0 = mul, 1 = div
//   mdu_done_i                 single-cycle result pulse from MUL/DIV unit
//   mdu_kill_o                 single-cycle abort pulse to MUL/DIV unit
//   out_valid_o / out_ready_i  handshake towards the next stage
//   err_illegal_o              sticky: illegal op class accepted
//   err_timeout_o              sticky: MUL/DIV unit exceeded MDU_TIMEOUT
// ---------------------------------------------------------------------------
module ysyx_22050854_exu_seq
    import ysyx_22050854_pkg::*;
#(
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 7
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [2:0] in_opc_i,
    input  logic       flush_i,
    output logic       ALUsrc1_o,
    output logic [1:0] ALUsrc2_o,
    output logic       mdu_valid_o,
    input  logic       mdu_ready_i,
    output logic       mdu_is_div_o,
    input  logic       mdu_done_i,
    output logic       mdu_kill_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic       err_illegal_o,
    output logic       err_timeout_o
);

    exu_state_e       state_q, state_d;
    logic             src1_q;
    logic [1:0]       src2_q;
    logic             isDiv_q;
    logic             kill_q, kill_d;
    logic             errIllegal_q;
    logic             errTimeout_q, errTimeout_d;
    logic [CNT_W-1:0] waitCnt_q, waitCnt_d;

    logic             decSrc1;
    logic [1:0]       decSrc2;
    logic             decIsMdu;
    logic             decIsDiv;
    logic             decIsIll;
    logic             accept;
    logic             timeoutHit;
    exu_state_e       acceptState;

    ysyx_22050854_exu_sel_dec u_sel_dec (
        .opc_i   (in_opc_i),
        .src1_o  (decSrc1),
        .src2_o  (decSrc2),
        .isMdu_o (decIsMdu),
        .isDiv_o (decIsDiv),
        .isIll_o (decIsIll)
    );

    // Handshake towards ID. A new op can enter when idle, or when the current
    // result is leaving this very cycle; a flush blocks any accept.
    always_comb begin
        in_ready_o  = ~flush_i & ((state_q == S_IDLE) |
                                  ((state_q == S_DONE) & out_ready_i));
        accept      = in_valid_i & in_ready_o;
        timeoutHit  = (waitCnt_q == CNT_W'(MDU_TIMEOUT - 1));
        acceptState = decIsMdu ? S_REQ : S_DONE;
    end

    // Next-state logic. Flush wins over everything; it only kills the MUL/DIV
    // unit when the unit actually owns the request (already waiting, or taking
    // it in this same cycle).
    always_comb begin
        state_d      = state_q;
        kill_d       = 1'b0;
        errTimeout_d = errTimeout_q;
        waitCnt_d    = (state_q == S_WAIT) ? (waitCnt_q + CNT_W'(1)) : '0;
        if (flush_i) begin
            state_d = S_IDLE;
            kill_d  = (state_q == S_WAIT) | ((state_q == S_REQ) & mdu_ready_i);
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_d = acceptState;
                    end
                end
                S_REQ: begin
                    if (mdu_ready_i) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mdu_done_i) begin
                        state_d = S_DONE;
                    end else if (timeoutHit) begin
                        state_d      = S_DONE;
                        errTimeout_d = 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        state_d = accept ? acceptState : S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, counter and sticky error registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            kill_q       <= 1'b0;
            errTimeout_q <= 1'b0;
            waitCnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            kill_q       <= kill_d;
            errTimeout_q <= errTimeout_d;
            waitCnt_q    <= waitCnt_d;
        end
    end

    // Operand selects and the mul/div flag are captured only on accept, so
    // they stay constant for the whole life of the op, flush included.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            src1_q       <= SRC1_RS1;
            src2_q       <= SRC2_RS2;
            isDiv_q      <= 1'b0;
            errIllegal_q <= 1'b0;
        end else if (accept) begin
            src1_q  <= decSrc1;
            src2_q  <= decSrc2;
            isDiv_q <= decIsDiv;
            if (decIsIll) begin
                errIllegal_q <= 1'b1;
            end
        end
    end

    // Moore-style outputs decoded from the state register.
    always_comb begin
        ALUsrc1_o     = src1_q;
        ALUsrc2_o     = src2_q;
        mdu_valid_o   = (state_q == S_REQ);
        mdu_is_div_o  = isDiv_q;
        mdu_kill_o    = kill_q;
        out_valid_o   = (state_q == S_DONE);
        err_illegal_o = errIllegal_q;
        err_timeout_o = errTimeout_q;
    end

endmodule

// File: tb/tb_ysyx_22050854_exu_seq.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22050854_exu_seq
// Directed self-checking bench for the execute-stage sequencer. The DUT runs
// with a short MUL/DIV timeout so the timeout path is reached quickly.
// ---------------------------------------------------------------------------
module tb_ysyx_22050854_exu_seq;

    localparam int TIMEOUT = 16;

    localparam logic [2:0] OP_OP    = 3'd0;
    localparam logic [2:0] OP_OPIMM = 3'd1;
    localparam logic [2:0] OP_AUIPC = 3'd2;
    localparam logic [2:0] OP_JUMP  = 3'd3;
    localparam logic [2:0] OP_LDST  = 3'd4;
    localparam logic [2:0] OP_MUL   = 3'd5;
    localparam logic [2:0] OP_DIV   = 3'd6;
    localparam logic [2:0] OP_ILL   = 3'd7;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       inValid;
    logic       inReady;
    logic [2:0] inOpc;
    logic       flush;
    logic       aluSrc1;
    logic [1:0] aluSrc2;
    logic       mduValid;
    logic       mduReady;
    logic       mduIsDiv;
    logic       mduDone;
    logic       mduKill;
    logic       outValid;
    logic       outReady;
    logic       errIllegal;
    logic       errTimeout;

    int checkCount = 0;
    int errorCount = 0;

    ysyx_22050854_exu_seq #(
        .MDU_TIMEOUT (TIMEOUT),
        .CNT_W       (7)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .in_valid_i    (inValid),
        .in_ready_o    (inReady),
        .in_opc_i      (inOpc),
        .flush_i       (flush),
        .ALUsrc1_o     (aluSrc1),
        .ALUsrc2_o     (aluSrc2),
        .mdu_valid_o   (mduValid),
        .mdu_ready_i   (mduReady),
        .mdu_is_div_o  (mduIsDiv),
        .mdu_done_i    (mduDone),
        .mdu_kill_o    (mduKill),
        .out_valid_o   (outValid),
        .out_ready_i   (outReady),
        .err_illegal_o (errIllegal),
        .err_timeout_o (errTimeout)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports any difference
    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive every DUT input for the coming clock edge
    task automatic applyStimulus(input logic valid, input logic [2:0] opc,
                                 input logic outRdy, input logic fl,
                                 input logic mduRdy, input logic mduDn);
        inValid  = valid;
        inOpc    = opc;
        outReady = outRdy;
        flush    = fl;
        mduReady = mduRdy;
        mduDone  = mduDn;
    endtask

    // Advance one clock and settle just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkSel(input string tag, input logic s1, input logic [1:0] s2);
        checkOutput({tag, "_src1"}, {7'd0, aluSrc1}, {7'd0, s1});
        checkOutput({tag, "_src2"}, {6'd0, aluSrc2}, {6'd0, s2});
    endtask

    // Directed scenarios, each followed by hand-computed expectations
    initial begin
        applyStimulus(1'b0, OP_OP, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #2;
        checkOutput("rst_out_valid", {7'd0, outValid}, 8'd0);
        checkOutput("rst_mdu_valid", {7'd0, mduValid}, 8'd0);
        checkOutput("rst_mdu_kill", {7'd0, mduKill}, 8'd0);
        checkOutput("rst_is_div", {7'd0, mduIsDiv}, 8'd0);
        checkOutput("rst_err_ill", {7'd0, errIllegal}, 8'd0);
        checkOutput("rst_err_to", {7'd0, errTimeout}, 8'd0);
        checkSel("rst", 1'b0, 2'b00);
        @(negedge clk);
        rst = 1'b0;

        // AUIPC then JUMP back-to-back with the next stage always ready
        applyStimulus(1'b1, OP_AUIPC, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 checkOutput("idle_in_ready", {7'd0, inReady}, 8'd1);
        tick();
        checkOutput("auipc_out_valid", {7'd0, outValid}, 8'd1);
        checkSel("auipc", 1'b1, 2'b01);
        applyStimulus(1'b1, OP_JUMP, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 checkOutput("done_in_ready", {7'd0, inReady}, 8'd1);
        tick();
        checkOutput("jump_out_valid", {7'd0, outValid}, 8'd1);
        checkSel("jump", 1'b1, 2'b10);
        applyStimulus(1'b1, OP_OPIMM, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkSel("opimm", 1'b0, 2'b01);
        applyStimulus(1'b1, OP_OP, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkSel("op", 1'b0, 2'b00);
        applyStimulus(1'b1, OP_LDST, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkSel("ldst", 1'b0, 2'b01);
        checkOutput("ldst_out_valid", {7'd0, outValid}, 8'd1);
        applyStimulus(1'b0, OP_OP, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("drain_out_valid", {7'd0, outValid}, 8'd0);
        checkSel("drain_hold", 1'b0, 2'b01);

        // MUL: unit ready on third request cycle, done on tenth wait cycle
        applyStimulus(1'b1, OP_MUL, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("mul_req1_valid", {7'd0, mduValid}, 8'd1);
        checkOutput("mul_is_div", {7'd0, mduIsDiv}, 8'd0);
        checkOutput("mul_req_out_valid", {7'd0, outValid}, 8'd0);
        checkSel("mul", 1'b0, 2'b00);
        applyStimulus(1'b0, OP_OP, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("mul_req2_valid", {7'd0, mduValid}, 8'd1);
        tick();
        checkOutput("mul_req3_valid", {7'd0, mduValid}, 8'd1);
        applyStimulus(1'b0, OP_OP, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("mul_wait_mdu_valid", {7'd0, mduValid}, 8'd0);
        applyStimulus(1'b0, OP_OP, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            checkOutput("mul_wait_out_valid", {7'd0, outValid}, 8'd0);
            tick();
        end
        applyStimulus(1'b0, OP_OP, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("mul_done_out_valid", {7'd0, outValid}, 8'd1);
        applyStimulus(1'b1, OP_OP, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 checkOutput("stall_in_ready", {7'd0, inReady}, 8'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("stall_out_valid", {7'd0, outValid}, 8'd1);
        end
        applyStimulus(1'b0, OP_OP, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("mul_drain_out_valid", {7'd0, outValid}, 8'd0);
        checkOutput("mul_err_to", {7'd0, errTimeout}, 8'd0);

        // DIV flushed five cycles into the wait phase
        applyStimulus(1'b1, OP_DIV, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("div_mdu_valid", {7'd0, mduValid}, 8'd1);
        checkOutput("div_is_div", {7'd0, mduIsDiv}, 8'd1);
        applyStimulus(1'b0, OP_OP, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, OP_OP, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            checkOutput("div_wait_kill", {7'd0, mduKill}, 8'd0);
            tick();
        end
        applyStimulus(1'b1, OP_OP, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 checkOutput("flush_in_ready", {7'd0, inReady}, 8'd0);
        tick();
        checkOutput("flush_kill", {7'd0, mduKill}, 8'd1);
        checkOutput("flush_out_valid", {7'd0, outValid}, 8'd0);
        checkOutput("flush_mdu_valid", {7'd0, mduValid}, 8'd0);
        applyStimulus(1'b0, OP_OP, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 checkOutput("post_flush_in_ready", {7'd0, inReady}, 8'd1);
        tick();
        checkOutput("kill_pulse_end", {7'd0, mduKill}, 8'd0);
        checkOutput("post_flush_out_valid", {7'd0, outValid}, 8'd0);

        // Flush in request phase: no kill without handshake, kill with it
        applyStimulus(1'b1, OP_MUL, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, OP_OP, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("req_flush_no_kill", {7'd0, mduKill}, 8'd0);
        checkOutput("req_flush_mdu_valid", {7'd0, mduValid}, 8'd0);
        applyStimulus(1'b1, OP_MUL, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, OP_OP, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("req_flush_hs_kill", {7'd0, mduKill}, 8'd1);
        applyStimulus(1'b0, OP_OP, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("req_flush_hs_kill_end", {7'd0, mduKill}, 8'd0);
        checkOutput("req_flush_out_valid", {7'd0, outValid}, 8'd0);

        // DIV that never completes: timeout after TIMEOUT wait cycles
        applyStimulus(1'b1, OP_DIV, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, OP_OP, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, OP_OP, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= TIMEOUT; i++) begin
            checkOutput("to_wait_err", {7'd0, errTimeout}, 8'd0);
            checkOutput("to_wait_out_valid", {7'd0, outValid}, 8'd0);
            tick();
        end
        checkOutput("to_err", {7'd0, errTimeout}, 8'd1);
        checkOutput("to_out_valid", {7'd0, outValid}, 8'd1);
        applyStimulus(1'b0, OP_OP, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("to_drain_out_valid", {7'd0, outValid}, 8'd0);
        checkOutput("to_err_sticky", {7'd0, errTimeout}, 8'd1);

        // Illegal op after a JUMP, then spurious done pulses
        applyStimulus(1'b1, OP_JUMP, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkSel("pre_ill", 1'b1, 2'b10);
        applyStimulus(1'b1, OP_ILL, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("ill_err", {7'd0, errIllegal}, 8'd1);
        checkOutput("ill_out_valid", {7'd0, outValid}, 8'd1);
        checkSel("ill", 1'b0, 2'b00);
        applyStimulus(1'b0, OP_OP, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("ill_drain_out_valid", {7'd0, outValid}, 8'd0);
        applyStimulus(1'b0, OP_OP, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("spur_out_valid", {7'd0, outValid}, 8'd0);
        checkOutput("spur_mdu_valid", {7'd0, mduValid}, 8'd0);
        checkOutput("spur_in_ready", {7'd0, inReady}, 8'd1);
        checkOutput("ill_err_sticky", {7'd0, errIllegal}, 8'd1);

        // Asynchronous reset while waiting on the MUL/DIV unit
        applyStimulus(1'b1, OP_AUIPC, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, OP_MUL, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, OP_OP, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, OP_OP, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        checkOutput("arst_out_valid", {7'd0, outValid}, 8'd0);
        checkOutput("arst_mdu_valid", {7'd0, mduValid}, 8'd0);
        checkOutput("arst_kill", {7'd0, mduKill}, 8'd0);
        checkOutput("arst_err_ill", {7'd0, errIllegal}, 8'd0);
        checkOutput("arst_err_to", {7'd0, errTimeout}, 8'd0);
        checkSel("arst", 1'b0, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        #1 checkOutput("arst_in_ready", {7'd0, inReady}, 8'd1);
        tick();
        checkOutput("arst_idle_out_valid", {7'd0, outValid}, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
